fetch_queue_stage: RTL and testbench
====================================

Name: fetch_queue_stage

Overview:
- Parametrised next-generation fetch stage: decouples instruction memory from decode with a DEPTH-entry prefetch queue and pipelined, in-order imem requests.
- Supports up to DEPTH outstanding requests with valid/ready request and rvalid response handshakes.
- Redirects (trap, mret, jump, fence) flush the queue and discard in-flight responses; fence drains memory before restarting.
- Sits between the CSR/decode redirect sources and the decode stage.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, queue entries and maximum outstanding requests (power of 2, >=2)
RESET_PC, 0, first fetch address after reset

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
trap  in  1  take trap, redirect to mtvec
mtvec  in  XLEN  trap target
mret  in  1  return, redirect to mepc
mepc  in  XLEN  return target
jump  in  1  decode branch/jump redirect
jump_addr  in  XLEN  jump target
fence  in  1  fence.i: drain, then refetch at fence_npc
fence_npc  in  XLEN  address after fence
mem_valid  out  1  request valid
mem_ready  in  1  memory accepts request
mem_addr  out  XLEN  request address
mem_spec  out  1  first request after a redirect
mem_fence  out  1  one-cycle cache-invalidate pulse
mem_instr  out  1  constant 1
mem_rvalid  in  1  response valid (in order)
mem_rdata  in  XLEN  response instruction
y_valid  out  1  queue head valid
y_pc  out  XLEN  head pc
y_instr  out  XLEN  head instruction
y_ready  in  1  decode consumes head

Behaviour:
- Reset (synchronous, active-high): queue empty, outstanding=0, drop=0, pc=RESET_PC, spec=1, state RUN. Outputs: mem_valid=0, mem_fence=0, mem_spec=1, mem_addr=RESET_PC, y_valid=0. Reset mid-operation discards everything; responses arriving in the cycle reset is high are ignored. drop=0 after reset, so the memory must not deliver stale responses after reset.
- Redirect priority: trap > mret > jump > fence.
- Redirect in cycle N (trap/mret/jump):
  - queue cleared; pc=target; spec=1;
  - drop = outstanding, plus 1 if a request handshakes in N;
  - mem_valid=0 in N; new request from cycle N+1.
- Fence in cycle N:
  - same flush, pc=fence_npc, then state FENCE_WAIT.
  - In FENCE_WAIT: mem_valid=0; once outstanding==0, assert mem_fence=1 for exactly one cycle, return to RUN, and request on the next cycle.
  - A trap/mret/jump during FENCE_WAIT overrides the fence and returns to RUN; the mem_fence pulse is lost.
- Issue rule (RUN): mem_valid=1 when queue_count+outstanding < DEPTH.
  - Handshake (mem_valid&mem_ready): outstanding+1, pc+=4 (XLEN wrap), spec=0.
  - mem_addr/mem_spec stay stable while mem_valid&~mem_ready.
- Response: on mem_rvalid with drop>0, drop-1 and data discarded. Otherwise {pc_tag, rdata} is written to the queue tail and outstanding-1. pc_tag comes from a DEPTH-entry in-order address FIFO written at issue.
- Latency: response at cycle N makes y_valid=1 at N+1, since the queue is registered with no bypass.
- Pop: y_valid&y_ready moves head forward one cycle later. Simultaneous push and pop allowed even when full; count unchanged.
- Simultaneous events:
  - redirect + pop: pop ignored, queue cleared.
  - redirect + rvalid: response counted into drop accounting (discarded).
  - redirect + handshake: covered by the drop rule above.
- Pointers: log2(DEPTH) bits, natural wrap; count 0..DEPTH. Full blocks issue, so the queue never overflows; rvalid with queue full is impossible by credit.

Decomposition:
- Shared package: fetch_queue_state_type enum {RUN, FENCE_WAIT}; fetch_queue_entry_type {pc, instr}; fetch_queue_reg_type plus init_fetch_queue_reg.
- One sub-module, fetch_fifo: parametrised synchronous FIFO (WIDTH, DEPTH, push, pop, clear, count, head). Instantiated twice: instruction queue and in-flight pc-tag FIFO.

Test Plan:
- Reset, mem_ready=1, 1-cycle response: requests 0x0, 0x4, 0x8, 0xC back-to-back. y shows pc 0x0 with rdata one cycle after the first rvalid. With y_ready=0, mem_valid falls after DEPTH=4 credits.
- Jump to 0x100 with 2 outstanding: next two rvalid discarded. First request 0x100 carries mem_spec=1, then 0x104 carries mem_spec=0. y_valid=0 until the 0x100 data arrives.
- Fence, fence_npc=0x40, 3 outstanding, response latency 3: mem_fence pulses once after the third rvalid. Request 0x40 follows next cycle; no stale data reaches y.
- Trap (mtvec=0x200) and jump in the same cycle, during FENCE_WAIT: fetch restarts at 0x200 and no mem_fence pulse occurs.
- mem_ready held 0 for 5 cycles: mem_addr and mem_spec stable; outstanding unchanged.
- Full queue with simultaneous rvalid and pop: count stays 4; order preserved; pc wraps 0xFFFFFFFC -> 0x0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue stage: control state, queue entry layout
// and the control register bundle with its reset value.
package fetch_queue_pkg;

  localparam int FQ_XLEN  = 32;
  // Wide enough to count responses still owed by memory across back-to-back redirects.
  localparam int FQ_CNT_W = 8;

  typedef enum logic {
    RUN        = 1'b0,
    FENCE_WAIT = 1'b1
  } fetch_queue_state_type;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
  } fetch_queue_entry_type;

  typedef struct packed {
    fetch_queue_state_type state;
    logic                  spec;
    logic [FQ_CNT_W-1:0]   drop;
  } fetch_queue_reg_type;

  function automatic fetch_queue_reg_type init_fetch_queue_reg();
    fetch_queue_reg_type r;
    r.state = RUN;
    r.spec  = 1'b1;
    r.drop  = '0;
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// Synchronous FIFO with clear, used for both the instruction queue and the
// in-flight request pc tags. Push and pop may coincide even when full.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: non-blocking assignments for all flops, so evaluation order between
  // always_ff blocks can never change what gets captured.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides validity.
  always_ff @(posedge clock) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: issues in-order pipelined imem requests under a credit limit,
// buffers responses for decode and handles trap/mret/jump/fence redirects.
module fetch_queue_stage
  import fetch_queue_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            trap,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_addr,
  input  logic            fence,
  input  logic [XLEN-1:0] fence_npc,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_spec,
  output logic            mem_fence,
  output logic            mem_instr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            y_valid,
  output logic [XLEN-1:0] y_pc,
  output logic [XLEN-1:0] y_instr,
  input  logic            y_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_queue_reg_type r_q, r_d;
  logic [XLEN-1:0]     pc_q, pc_d;

  logic              ctrl_redirect, redirect;
  logic [XLEN-1:0]   target;
  logic              hs, rsp_keep, pop;
  logic [CNT_W-1:0]  q_count, tag_count;
  logic [2*XLEN-1:0] q_head;
  logic [XLEN-1:0]   tag_head;
  logic [FQ_CNT_W-1:0] credit_used;

  assign ctrl_redirect = trap | mret | jump;
  assign redirect      = ctrl_redirect | fence;

  always_comb begin
    target = fence_npc;
    if (trap)      target = mtvec;
    else if (mret) target = mepc;
    else if (jump) target = jump_addr;
  end

  // Outstanding requests are exactly the live pc tags still waiting for data.
  assign credit_used = FQ_CNT_W'(q_count) + FQ_CNT_W'(tag_count);

  assign mem_valid = !reset && (r_q.state == RUN) && !redirect &&
                     (credit_used < FQ_CNT_W'(DEPTH));
  assign mem_fence = !reset && (r_q.state == FENCE_WAIT) && !redirect &&
                     (r_q.drop == '0) && (tag_count == '0);
  assign mem_addr  = pc_q;
  assign mem_spec  = r_q.spec;
  assign mem_instr = 1'b1;

  assign hs       = mem_valid && mem_ready;
  assign rsp_keep = mem_rvalid && (r_q.drop == '0) && !redirect;
  assign pop      = y_valid && y_ready && !redirect;

  always_comb begin
    r_d  = r_q;
    pc_d = pc_q;
    if (hs) begin
      pc_d   = pc_q + XLEN'(4);
      r_d.spec = 1'b0;
    end
    if (mem_rvalid && (r_q.drop != '0)) r_d.drop = r_q.drop - FQ_CNT_W'(1);
    if (mem_fence) r_d.state = RUN;
    if (redirect) begin
      pc_d      = target;
      r_d.spec  = 1'b1;
      // Everything still owed by memory becomes garbage, minus a response landing now.
      r_d.drop  = r_q.drop + FQ_CNT_W'(tag_count) - FQ_CNT_W'(mem_rvalid);
      r_d.state = ctrl_redirect ? RUN : FENCE_WAIT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q  <= init_fetch_queue_reg();
      pc_q <= RESET_PC;
    end else begin
      r_q  <= r_d;
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect),
    .push      (hs),
    .push_data (pc_q),
    .pop       (rsp_keep),
    .count     (tag_count),
    .head      (tag_head)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_queue (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect),
    .push      (rsp_keep),
    .push_data ({tag_head, mem_rdata}),
    .pop       (pop),
    .count     (q_count),
    .head      (q_head)
  );

  assign y_valid = (q_count != '0);
  assign y_pc    = q_head[2*XLEN-1:XLEN];
  assign y_instr = q_head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: in-order memory with variable latency, a
// transaction-level reference model checked every cycle, plus directed scenarios.
`timescale 1ns/1ps
module tb_fetch_queue_stage;
  import fetch_queue_pkg::*;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clock = 1'b0;
  logic        reset;
  logic        trap, mret, jump, fence;
  logic [31:0] mtvec, mepc, jump_addr, fence_npc;
  logic        mem_valid, mem_ready, mem_spec, mem_fence, mem_instr, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        y_valid, y_ready;
  logic [31:0] y_pc, y_instr;

  fetch_queue_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .trap(trap), .mtvec(mtvec), .mret(mret), .mepc(mepc),
    .jump(jump), .jump_addr(jump_addr), .fence(fence), .fence_npc(fence_npc),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_spec(mem_spec), .mem_fence(mem_fence), .mem_instr(mem_instr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .y_valid(y_valid), .y_pc(y_pc), .y_instr(y_instr), .y_ready(y_ready)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory environment ----------------
  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } mreq_t;
  mreq_t pend[$];
  int cyc     = 0;
  int lat_min = 1, lat_max = 1;
  int rdy_pct = 100, rsp_pct = 100;

  task automatic drive_mem();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (!reset && pend.size() > 0 && pend[0].due <= cyc &&
        $urandom_range(99, 0) < rsp_pct) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pend[0].data;
    end
    mem_ready = ($urandom_range(99, 0) < rdy_pct);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; bit live; } fl_t;
  fl_t                   fl[$];
  fetch_queue_entry_type yq[$];
  logic [31:0] m_pc;
  bit          m_spec, m_fwait;
  bit          m_redir, e_valid, e_fence;
  int          live_n;
  fl_t         m_f;
  fetch_queue_entry_type m_e;

  always @(negedge clock) begin : monitor
    if (reset) begin
      fl.delete(); yq.delete(); pend.delete();
      m_pc = RESET_PC; m_spec = 1'b1; m_fwait = 1'b0;
    end else begin
      m_redir = trap | mret | jump | fence;
      live_n = 0;
      foreach (fl[i]) if (fl[i].live) live_n++;
      e_valid = !m_fwait && !m_redir && (yq.size() + live_n < DEPTH);
      e_fence = m_fwait && (fl.size() == 0) && !m_redir;

      check("mem_valid", mem_valid, e_valid);
      check("mem_fence", mem_fence, e_fence);
      check("mem_addr",  mem_addr,  m_pc);
      check("mem_spec",  mem_spec,  m_spec);
      check("mem_instr", mem_instr, 1);
      check("y_valid",   y_valid,   yq.size() > 0);
      if (yq.size() > 0) begin
        check("y_pc",    y_pc,    yq[0].pc);
        check("y_instr", y_instr, yq[0].instr);
      end

      // environment bookkeeping, driven by what the DUT actually did
      if (mem_rvalid && pend.size() > 0) void'(pend.pop_front());
      if (mem_valid && mem_ready)
        pend.push_back('{mem_addr, $urandom, cyc + $urandom_range(lat_max, lat_min)});

      // model advance
      if (yq.size() > 0 && y_ready && !m_redir) m_e = yq.pop_front();
      if (mem_rvalid) begin
        check("rsp_has_request", fl.size() > 0, 1);
        if (fl.size() > 0) begin
          m_f = fl.pop_front();
          if (m_f.live && !m_redir) yq.push_back('{pc: m_f.pc, instr: mem_rdata});
        end
      end
      if (e_valid && mem_ready) begin
        fl.push_back('{m_pc, 1'b1});
        m_pc   = m_pc + 32'd4;
        m_spec = 1'b0;
      end
      if (m_redir) begin
        yq.delete();
        foreach (fl[i]) fl[i].live = 1'b0;
        m_pc    = trap ? mtvec : mret ? mepc : jump ? jump_addr : fence_npc;
        m_spec  = 1'b1;
        m_fwait = !(trap | mret | jump);
      end else if (e_fence) begin
        m_fwait = 1'b0;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    drive_mem();
    trap = 0; mret = 0; jump = 0; fence = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    #1;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_fence", mem_fence, 0);
    check("rst_mem_spec",  mem_spec,  1);
    check("rst_mem_addr",  mem_addr,  RESET_PC);
    check("rst_y_valid",   y_valid,   0);
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] d0, exp_pc;
  int          seen;

  initial begin
    reset = 1; trap = 0; mret = 0; jump = 0; fence = 0;
    mtvec = '0; mepc = '0; jump_addr = '0; fence_npc = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0; y_ready = 0;

    // back-to-back issue, 1-cycle memory, decode stalled
    rdy_pct = 100; lat_min = 1; lat_max = 1; y_ready = 0;
    do_reset();
    #1;
    check("t1_c1_valid", mem_valid, 1);
    check("t1_c1_addr",  mem_addr,  32'h0);
    check("t1_c1_spec",  mem_spec,  1);
    tick(); #1;
    check("t1_c2_addr",  mem_addr,  32'h4);
    check("t1_c2_spec",  mem_spec,  0);
    check("t1_c2_rvalid", mem_rvalid, 1);
    d0 = mem_rdata;
    tick(); #1;
    check("t1_c3_addr",    mem_addr, 32'h8);
    check("t1_c3_y_valid", y_valid,  1);
    check("t1_c3_y_pc",    y_pc,     32'h0);
    check("t1_c3_y_instr", y_instr,  d0);
    tick(); #1;
    check("t1_c4_addr", mem_addr, 32'hC);
    tick(); #1;
    check("t1_credit_stop", mem_valid, 0);

    // jump with two requests in flight
    lat_min = 3; lat_max = 3; y_ready = 1;
    do_reset();
    tick();
    tick(); jump = 1; jump_addr = 32'h100; #1;
    check("t2_jump_valid", mem_valid, 0);
    tick(); #1;
    check("t2_c4_addr",   mem_addr,   32'h100);
    check("t2_c4_spec",   mem_spec,   1);
    check("t2_c4_rvalid", mem_rvalid, 1);
    tick(); #1;
    check("t2_c5_addr", mem_addr, 32'h104);
    check("t2_c5_spec", mem_spec, 0);
    check("t2_c5_y",    y_valid,  0);
    tick(); #1; check("t2_c6_y", y_valid, 0);
    tick(); #1; check("t2_c7_y", y_valid, 0);
    tick(); #1;
    check("t2_c8_y",    y_valid, 1);
    check("t2_c8_y_pc", y_pc,    32'h100);

    // fence with three outstanding, latency 3
    do_reset();
    tick();
    tick();
    tick(); fence = 1; fence_npc = 32'h40; #1;
    check("t3_c4_valid", mem_valid, 0);
    tick(); #1; check("t3_c5_fence", mem_fence, 0); check("t3_c5_y", y_valid, 0);
    tick(); #1; check("t3_c6_fence", mem_fence, 0); check("t3_c6_valid", mem_valid, 0);
    tick(); #1;
    check("t3_c7_fence", mem_fence, 1);
    check("t3_c7_valid", mem_valid, 0);
    tick(); #1;
    check("t3_c8_fence", mem_fence, 0);
    check("t3_c8_valid", mem_valid, 1);
    check("t3_c8_addr",  mem_addr,  32'h40);
    check("t3_c8_spec",  mem_spec,  1);
    check("t3_c8_y",     y_valid,   0);

    // trap + jump during FENCE_WAIT
    do_reset();
    tick();
    tick();
    tick(); fence = 1; fence_npc = 32'h40;
    tick(); trap = 1; mtvec = 32'h200; jump = 1; jump_addr = 32'h300; #1;
    check("t4_c5_fence", mem_fence, 0);
    tick(); #1;
    check("t4_c6_valid", mem_valid, 1);
    check("t4_c6_addr",  mem_addr,  32'h200);
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      check("t4_no_pulse", mem_fence, 0);
    end

    // memory stalls the first request for 5 cycles
    rdy_pct = 0; lat_min = 1; lat_max = 1; y_ready = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      #1;
      check("t5_stall_valid", mem_valid, 1);
      check("t5_stall_addr",  mem_addr,  32'h0);
      check("t5_stall_spec",  mem_spec,  1);
      check("t5_stall_y",     y_valid,   0);
    end
    rdy_pct = 100;
    tick(); #1; check("t5_go_addr", mem_addr, 32'h0);
    tick(); #1; check("t5_next_addr", mem_addr, 32'h4); check("t5_next_spec", mem_spec, 0);

    // fill to full across the address wrap, then drain in order
    y_ready = 0;
    do_reset();
    jump = 1; jump_addr = 32'hFFFF_FFF8;
    for (int i = 0; i < 6; i++) tick();
    #1;
    check("t6_full_valid", mem_valid, 0);
    check("t6_full_y_pc",  y_pc,      32'hFFFF_FFF8);
    exp_pc = 32'hFFFF_FFFC;
    y_ready = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      if (y_valid) begin
        check("t6_order", y_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        seen++;
      end
    end
    check("t6_seen_enough", seen >= 6, 1);

    // randomized traffic with a mid-run reset
    lat_min = 1; lat_max = 4; rdy_pct = 70; rsp_pct = 80;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tick();
      y_ready = ($urandom_range(99, 0) < 60);
      if ($urandom_range(99, 0) < 2) begin trap  = 1; mtvec     = $urandom & 32'hFFFF_FFFC; end
      if ($urandom_range(99, 0) < 2) begin mret  = 1; mepc      = $urandom & 32'hFFFF_FFFC; end
      if ($urandom_range(99, 0) < 3) begin jump  = 1; jump_addr = $urandom & 32'hFFFF_FFFC; end
      if ($urandom_range(99, 0) < 2) begin fence = 1; fence_npc = $urandom & 32'hFFFF_FFFC; end
      if (i == 2000) reset = 1;
      if (i == 2002) reset = 0;
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
